boid_reg_snapshot: RTL and testbench

Captures the five exposed processor registers (r25–r29) as one atomic boid record whenever software commits a record by writing r29. Buffers the records in a small FIFO and hands them to the boid graphics/physics engine over a valid/ready handshake. Sits directly downstream of the processor register file: it observes the register file write port and consumes the `reg_out25`..`reg_out29` taps.

---
 rtl/boid_reg_snapshot.sv | 105 ++++++++++
 tb/tb_boid_reg_snapshot.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_reg_snapshot.sv
// boid_reg_snapshot: captures r25..r29 as one atomic boid record on every r29
// commit and queues the records for the boid engine over a valid/ready handshake.
module boid_reg_snapshot #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned COMMIT_REG = 29
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  input  logic                   ctrl_writeEnable,
  input  logic [4:0]             ctrl_writeReg,
  input  logic [31:0]            reg_out25,
  input  logic [31:0]            reg_out26,
  input  logic [31:0]            reg_out27,
  input  logic [31:0]            reg_out28,
  input  logic [31:0]            reg_out29,
  output logic                   boid_valid,
  input  logic                   boid_ready,
  output logic [159:0]           boid_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic [7:0]             overflow_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REC_W = 160;

  logic             pending;
  logic             commitDet;
  logic             doPush;
  logic             doPop;
  logic             pushAccept;
  logic             dropRec;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrNext;
  logic [CNT_W-1:0] countNext;
  logic [7:0]       overflowNext;
  logic [REC_W-1:0] sampleRec;
  logic [REC_W-1:0] mem [DEPTH];

  // The register file updates r29 on the commit edge, so the record is sampled one cycle later.
  always_comb begin
    commitDet    = ctrl_writeEnable && (ctrl_writeReg == 5'(COMMIT_REG));
    sampleRec    = {reg_out29, reg_out28, reg_out27, reg_out26, reg_out25};
    doPush       = pending;
    doPop        = boid_valid && boid_ready;
    pushAccept   = doPush && (!fifo_full || doPop);
    dropRec      = doPush && fifo_full && !doPop;

    wrPtrNext    = wrPtr;
    rdPtrNext    = rdPtr;
    countNext    = fifo_count;
    overflowNext = overflow_cnt;

    if (pushAccept) begin
      wrPtrNext = PTR_W'(wrPtr + 1'b1);
    end
    if (doPop) begin
      rdPtrNext = PTR_W'(rdPtr + 1'b1);
    end

    if (pushAccept && !doPop) begin
      countNext = CNT_W'(fifo_count + 1'b1);
    end else if (!pushAccept && doPop) begin
      countNext = CNT_W'(fifo_count - 1'b1);
    end

    if (dropRec && (overflow_cnt != 8'hFF)) begin
      overflowNext = 8'(overflow_cnt + 8'd1);
    end
  end

  // Control state; valid/full are decoded from the next count so they stay registered.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pending      <= 1'b0;
      wrPtr        <= '0;
      rdPtr        <= '0;
      fifo_count   <= '0;
      boid_valid   <= 1'b0;
      fifo_full    <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      pending      <= commitDet;
      wrPtr        <= wrPtrNext;
      rdPtr        <= rdPtrNext;
      fifo_count   <= countNext;
      boid_valid   <= (countNext != '0);
      fifo_full    <= (countNext == CNT_W'(DEPTH));
      overflow_cnt <= overflowNext;
    end
  end

  // Record storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (pushAccept) begin
      mem[wrPtr] <= sampleRec;
    end
  end

  assign boid_data = mem[rdPtr];

endmodule

// File: tb/tb_boid_reg_snapshot.sv
// Self-checking bench for boid_reg_snapshot: directed table, corner sequences,
// and randomized traffic against a queue-based record model.
module tb_boid_reg_snapshot;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          we = 1'b0;
  logic [4:0]    wr = 5'd0;
  logic [31:0]   wd = 32'd0;
  logic          sideWe = 1'b0;
  logic [4:0]    sideIdx = 5'd0;
  logic [31:0]   sideData = 32'd0;
  logic          ready = 1'b0;
  logic [31:0]   rf [32] = '{default: 32'h0};

  logic          boidValid;
  logic [159:0]  boidData;
  logic [CW-1:0] fifoCount;
  logic          fifoFull;
  logic [7:0]    overflowCnt;

  int nAssert = 0;
  int nFail   = 0;

  // Bench-side register file with a second write port for the side updates.
  always @(posedge clk) begin
    if (we) rf[wr] <= wd;
    if (sideWe) rf[sideIdx] <= sideData;
  end

  always #5 clk = ~clk;

  boid_reg_snapshot #(.DEPTH(DEPTH), .COMMIT_REG(29)) dut (
    .clock(clk), .ctrl_reset_n(rstN),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr),
    .reg_out25(rf[25]), .reg_out26(rf[26]), .reg_out27(rf[27]),
    .reg_out28(rf[28]), .reg_out29(rf[29]),
    .boid_valid(boidValid), .boid_ready(ready), .boid_data(boidData),
    .fifo_count(fifoCount), .fifo_full(fifoFull), .overflow_cnt(overflowCnt)
  );

  // Reference model: commits waiting to be sampled, and the queued records.
  logic [159:0] mq [$];
  int           mOvf;
  bit           mPend;

  task automatic modelReset();
    mq.delete();
    mOvf  = 0;
    mPend = 1'b0;
  endtask

  // Called right after a rising edge, before the register file write lands.
  task automatic modelEdge();
    if (mq.size() != 0 && ready) void'(mq.pop_front());
    if (mPend) begin
      if (mq.size() < DEPTH) mq.push_back({rf[29], rf[28], rf[27], rf[26], rf[25]});
      else if (mOvf < 255) mOvf++;
    end
    mPend = we && (wr == 5'd29);
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    chk("model_count", 160'(fifoCount), 160'(mq.size()));
    chk("model_valid", 160'(boidValid), 160'(mq.size() != 0));
    chk("model_full", 160'(fifoFull), 160'(mq.size() == DEPTH));
    chk("model_ovf", 160'(overflowCnt), 160'(mOvf));
    if (mq.size() != 0) chk("model_data", boidData, mq[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic drive(input logic w, input logic [4:0] r, input logic [31:0] d, input logic rd);
    we = w; wr = r; wd = d; ready = rd;
  endtask

  // Asynchronous reset pulse placed between edges; release on a falling edge.
  task automatic midReset();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    sideWe = 1'b0;
    #2 rstN = 1'b0;
    modelReset();
    #1;
    chk("rst_valid", 160'(boidValid), 160'(0));
    chk("rst_count", 160'(fifoCount), 160'(0));
    chk("rst_full", 160'(fifoFull), 160'(0));
    chk("rst_ovf", 160'(overflowCnt), 160'(0));
    @(negedge clk);
    rstN = 1'b1;
  endtask

  typedef struct {
    logic         we;
    logic [4:0]   wr;
    logic [31:0]  wd;
    logic         rdy;
    int unsigned  eCount;
    logic         eValid;
    logic         chkData;
    logic [159:0] eData;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] r, input logic [31:0] d,
                              input logic rd, input int unsigned c, input logic v,
                              input logic cd, input logic [159:0] ed);
    vec_t x;
    x.we = w; x.wr = r; x.wd = d; x.rdy = rd;
    x.eCount = c; x.eValid = v; x.chkData = cd; x.eData = ed;
    return x;
  endfunction

  vec_t tbl [13];
  int   popIdx;
  int   rdyPct;

  initial begin
    tbl[0]  = mk(1, 25, 32'h11, 0, 0, 0, 0, '0);
    tbl[1]  = mk(1, 26, 32'h22, 0, 0, 0, 0, '0);
    tbl[2]  = mk(1, 27, 32'h33, 0, 0, 0, 0, '0);
    tbl[3]  = mk(1, 28, 32'h44, 0, 0, 0, 0, '0);
    tbl[4]  = mk(1, 29, 32'hA5, 0, 0, 0, 0, '0);
    tbl[5]  = mk(0, 0, 32'h0, 0, 1, 1, 1, {32'hA5, 32'h44, 32'h33, 32'h22, 32'h11});
    tbl[6]  = mk(0, 0, 32'h0, 1, 0, 0, 0, '0);
    tbl[7]  = mk(1, 25, 32'h1, 0, 0, 0, 0, '0);
    tbl[8]  = mk(1, 28, 32'h5, 0, 0, 0, 0, '0);
    tbl[9]  = mk(1, 26, 32'h6, 0, 0, 0, 0, '0);
    tbl[10] = mk(0, 29, 32'h7, 0, 0, 0, 0, '0);
    tbl[11] = mk(0, 29, 32'h8, 1, 0, 0, 0, '0);
    tbl[12] = mk(0, 0, 32'h0, 0, 0, 0, 0, '0);

    // Reset state
    modelReset();
    #3;
    chk("init_valid", 160'(boidValid), 160'(0));
    chk("init_count", 160'(fifoCount), 160'(0));
    chk("init_full", 160'(fifoFull), 160'(0));
    chk("init_ovf", 160'(overflowCnt), 160'(0));
    @(negedge clk);
    rstN = 1'b1;

    // Single record and non-commit writes
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d_count", i), 160'(fifoCount), 160'(tbl[i].eCount));
      chk($sformatf("tbl%0d_valid", i), 160'(boidValid), 160'(tbl[i].eValid));
      if (tbl[i].chkData) chk($sformatf("tbl%0d_data", i), boidData, tbl[i].eData);
    end

    // Back-to-back commits with r26 changing every cycle
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'd29, 32'(k), 1'b0);
      sideWe = 1'b1; sideIdx = 5'd26; sideData = 32'hB0 + 32'(k);
      tick();
    end
    sideWe = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    chk("b2b_count", 160'(fifoCount), 160'(3));
    for (int k = 1; k <= 3; k++) begin
      ready = 1'b1;
      chk("b2b_r29", 160'(boidData[159:128]), 160'(k));
      chk("b2b_r26", 160'(boidData[63:32]), 160'(32'hB0 + 32'(k)));
      tick();
    end
    ready = 1'b0;
    chk("b2b_empty", 160'(fifoCount), 160'(0));

    // Full and overflow
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd29, 32'h10 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    chk("ovf_full", 160'(fifoFull), 160'(1));
    chk("ovf_count", 160'(fifoCount), 160'(4));
    chk("ovf_cnt2", 160'(overflowCnt), 160'(2));
    for (int i = 0; i < 4; i++) begin
      ready = 1'b1;
      chk("ovf_drain", 160'(boidData[159:128]), 160'(32'h10 + 32'(i)));
      tick();
    end
    ready = 1'b0;
    chk("ovf_drained", 160'(fifoCount), 160'(0));
    for (int i = 0; i < 304; i++) begin
      drive(1'b1, 5'd29, 32'h300 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    chk("ovf_sat", 160'(overflowCnt), 160'(255));
    chk("ovf_sat_count", 160'(fifoCount), 160'(4));

    // Reset mid-stream: 3 records stored and a capture pending
    drive(1'b1, 5'd29, 32'h999, 1'b1);
    chk("mid_head", 160'(boidData[159:128]), 160'(32'h300));
    tick();
    chk("mid_pre_count", 160'(fifoCount), 160'(3));
    midReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_post_count", 160'(fifoCount), 160'(0));
      chk("mid_post_valid", 160'(boidValid), 160'(0));
    end

    // Full with simultaneous pop: pointers wrap, records stay in order
    popIdx = 0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 5'd29, 32'h100 + 32'(i), i >= 5);
      if (i >= 5) begin
        chk("fp_head", 160'(boidData[159:128]), 160'(32'h100 + 32'(popIdx)));
        popIdx++;
      end
      tick();
      if (i >= 4) begin
        chk("fp_count", 160'(fifoCount), 160'(4));
        chk("fp_ovf", 160'(overflowCnt), 160'(0));
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("fp_drained", 160'(fifoCount), 160'(0));

    // Commit in the first cycle after release is honoured
    midReset();
    drive(1'b1, 5'd29, 32'h77, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    chk("rel_valid", 160'(boidValid), 160'(1));
    chk("rel_r29", 160'(boidData[159:128]), 160'(32'h77));

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      rdyPct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 100; i++) begin
        we    = ($urandom_range(0, 3) != 0);
        wr    = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'(25 + $urandom_range(0, 4));
        wd    = $urandom;
        ready = ($urandom_range(0, 99) < rdyPct);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
